// File: rtl/pq_drain_reader.sv
// Read-side master for the priority queue core. A start pulse begins a drain.
// Each removed key/data pair is captured and handed downstream over valid/ready.
// Along the way it checks that keys leave in priority order and that every
// remove request is acknowledged in time.
module pq_drain_reader #(
    parameter int KW        = 8,
    parameter int DW        = 8,
    parameter int MIN_FIRST = 1,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] pop_len_i,
    input  logic             pq_empty_i,
    output logic             rm_req_o,
    input  logic             rm_ack_i,
    input  logic [KW-1:0]    rm_key_i,
    input  logic [DW-1:0]    rm_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [KW-1:0]    out_key_o,
    output logic [DW-1:0]    out_data_o,
    output logic [CNT_W-1:0] pop_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             order_err_o,
    output logic             tmo_err_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    // Last REQ cycle before a missing ack is declared a timeout.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        HOLD,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [KW-1:0]      out_key_q, out_key_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic [KW-1:0]      last_key_q, last_key_d;
    logic               last_vld_q, last_vld_d;
    logic               order_err_q, order_err_d;
    logic               tmo_err_q, tmo_err_d;
    logic               key_bad;

    // The new key breaks priority order relative to the previously captured one.
    assign key_bad = (MIN_FIRST != 0) ? (rm_key_i < last_key_q)
                                      : (rm_key_i > last_key_q);

    // State and datapath registers; reset aborts a drain at once.
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pop_cnt_q   <= '0;
            wait_q      <= '0;
            out_key_q   <= '0;
            out_data_q  <= '0;
            last_key_q  <= '0;
            last_vld_q  <= 1'b0;
            order_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pop_cnt_q   <= pop_cnt_d;
            wait_q      <= wait_d;
            out_key_q   <= out_key_d;
            out_data_q  <= out_data_d;
            last_key_q  <= last_key_d;
            last_vld_q  <= last_vld_d;
            order_err_q <= order_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // Next-state logic: drain sequencing, capture, order check and timeout.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path can infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        pop_cnt_d   = pop_cnt_q;
        wait_d      = wait_q;
        out_key_d   = out_key_q;
        out_data_d  = out_data_q;
        last_key_d  = last_key_q;
        last_vld_d  = last_vld_q;
        order_err_d = order_err_q;
        tmo_err_d   = tmo_err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d       = pop_len_i;
                    pop_cnt_d   = '0;
                    order_err_d = 1'b0;
                    tmo_err_d   = 1'b0;
                    last_vld_d  = 1'b0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                wait_d = '0;
                if (pq_empty_i || ((len_q != '0) && (pop_cnt_q == len_q))) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (rm_ack_i) begin
                    out_key_d  = rm_key_i;
                    out_data_d = rm_data_i;
                    if (last_vld_q && key_bad) begin
                        order_err_d = 1'b1;
                    end
                    last_key_d = rm_key_i;
                    last_vld_d = 1'b1;
                    state_d    = HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    // Saturate in drain-all mode; the drain itself keeps going.
                    if (pop_cnt_q != '1) begin
                        pop_cnt_d = pop_cnt_q + 1'b1;
                    end
                    state_d = CHECK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so reset drops them immediately.
    assign rm_req_o    = (state_q == REQ);
    assign out_valid_o = (state_q == HOLD);
    assign done_o      = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_key_o   = out_key_q;
    assign out_data_o  = out_data_q;
    assign pop_cnt_o   = pop_cnt_q;
    assign order_err_o = order_err_q;
    assign tmo_err_o   = tmo_err_q;

endmodule

// File: tb/tb_pq_drain_reader.sv
// Directed bench for pq_drain_reader: the bench plays the queue core and the consumer.
module tb_pq_drain_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] pop_len_i = '0;
    logic       pq_empty_i = 1'b0;
    logic       rm_req_o;
    logic       rm_ack_i = 1'b0;
    logic [7:0] rm_key_i = '0;
    logic [7:0] rm_data_i = '0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [7:0] out_key_o;
    logic [7:0] out_data_o;
    logic [7:0] pop_cnt_o;
    logic       busy_o;
    logic       done_o;
    logic       order_err_o;
    logic       tmo_err_o;

    int checks = 0;
    int failures = 0;

    pq_drain_reader #(.KW(8), .DW(8), .MIN_FIRST(1), .TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pop_len_i(pop_len_i),
        .pq_empty_i(pq_empty_i), .rm_req_o(rm_req_o), .rm_ack_i(rm_ack_i),
        .rm_key_i(rm_key_i), .rm_data_i(rm_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_key_o(out_key_o), .out_data_o(out_data_o),
        .pop_cnt_o(pop_cnt_o), .busy_o(busy_o), .done_o(done_o),
        .order_err_o(order_err_o), .tmo_err_o(tmo_err_o)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic do_start(input logic [7:0] len);
        @(negedge clk);
        start_i   = 1'b1;
        pop_len_i = len;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    // Act as the queue: wait for rm_req, ack one pair, check the capture.
    task automatic serve(input logic [7:0] k, input logic [7:0] d, input string nm);
        int n = 0;
        while (!rm_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rm_req_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_req: rm_req=%b required 1 within 50 cycles", nm, rm_req_o);
        end
        rm_ack_i  = 1'b1;
        rm_key_i  = k;
        rm_data_i = d;
        @(negedge clk);
        rm_ack_i  = 1'b0;
        checks++;
        if ({out_valid_o, rm_req_o, out_key_o, out_data_o} !== {1'b1, 1'b0, k, d}) begin
            failures++;
            $display("FAIL %s_capture: valid=%b req=%b key=%h data=%h required 1 0 %h %h",
                     nm, out_valid_o, rm_req_o, out_key_o, out_data_o, k, d);
        end
    endtask

    // Wait for the done pulse, check pop_cnt there, then one-cycle width and IDLE.
    task automatic wait_done(input logic [7:0] exp_cnt, input string nm);
        int n = 0;
        while (!done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({done_o, busy_o, pop_cnt_o} !== {1'b1, 1'b1, exp_cnt}) begin
            failures++;
            $display("FAIL %s_done: done=%b busy=%b pop_cnt=%0d required 1 1 %0d",
                     nm, done_o, busy_o, pop_cnt_o, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL %s_idle: done=%b busy=%b required 0 0", nm, done_o, busy_o);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        #1;
        checks++;
        if ({rm_req_o, out_valid_o, busy_o, done_o, order_err_o, tmo_err_o, pop_cnt_o, out_key_o}
            !== 22'd0) begin
            failures++;
            $display("FAIL reset_state: req=%b valid=%b busy=%b done=%b oerr=%b terr=%b cnt=%0d key=%h required all 0",
                     rm_req_o, out_valid_o, busy_o, done_o, order_err_o, tmo_err_o, pop_cnt_o, out_key_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Mid-drain reset while a remove request is outstanding.
        do_start(8'd3);
        while (!rm_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rm_req_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_before: rm_req=%b required 1", rm_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rm_req_o, out_valid_o, busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async: req=%b valid=%b busy=%b required 0 0 0",
                     rm_req_o, out_valid_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rm_req_o, busy_o, pop_cnt_o} !== 10'd0) begin
            failures++;
            $display("FAIL reset_idle: req=%b busy=%b cnt=%0d required 0 0 0",
                     rm_req_o, busy_o, pop_cnt_o);
        end
    endtask

    task automatic test_ack_outside_req();
        @(negedge clk);
        rm_ack_i = 1'b1;
        rm_key_i = 8'hAA;
        rm_data_i = 8'h55;
        @(negedge clk);
        rm_ack_i = 1'b0;
        checks++;
        if ({out_valid_o, out_key_o, busy_o} !== {1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL stray_ack: valid=%b key=%h busy=%b required 0 00 0",
                     out_valid_o, out_key_o, busy_o);
        end
    endtask

    task automatic test_fixed_pop();
        out_ready_i = 1'b1;
        do_start(8'd3);
        serve(8'd2, 8'h20, "fix0");
        serve(8'd5, 8'h50, "fix1");
        serve(8'd9, 8'h90, "fix2");
        wait_done(8'd3, "fix");
        checks++;
        if (order_err_o !== 1'b0) begin
            failures++;
            $display("FAIL fix_order: order_err=%b required 0", order_err_o);
        end
    endtask

    task automatic test_drain_all();
        int reqs = 0;
        int dones = 0;
        do_start(8'd0);
        serve(8'd1, 8'h01, "all0");
        serve(8'd1, 8'h02, "all1");
        serve(8'd4, 8'h03, "all2");
        serve(8'd6, 8'h04, "all3");
        pq_empty_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rm_req_o) reqs++;
            if (done_o) dones++;
        end
        checks++;
        if ({reqs, dones, pop_cnt_o, order_err_o} !== {32'd0, 32'd1, 8'd4, 1'b0}) begin
            failures++;
            $display("FAIL all_end: extra_req=%0d dones=%0d cnt=%0d oerr=%b required 0 1 4 0",
                     reqs, dones, pop_cnt_o, order_err_o);
        end
        pq_empty_i = 1'b0;
    endtask

    task automatic test_order_err();
        do_start(8'd2);
        serve(8'd7, 8'h77, "ord0");
        checks++;
        if (order_err_o !== 1'b0) begin
            failures++;
            $display("FAIL ord_first: order_err=%b required 0", order_err_o);
        end
        serve(8'd3, 8'h33, "ord1");
        checks++;
        if (order_err_o !== 1'b1) begin
            failures++;
            $display("FAIL ord_second: order_err=%b required 1", order_err_o);
        end
        wait_done(8'd2, "ord");
        checks++;
        if (order_err_o !== 1'b1) begin
            failures++;
            $display("FAIL ord_sticky: order_err=%b required 1", order_err_o);
        end
        pq_empty_i = 1'b1;
        do_start(8'd1);
        checks++;
        if (order_err_o !== 1'b0) begin
            failures++;
            $display("FAIL ord_clear: order_err=%b required 0", order_err_o);
        end
        wait_done(8'd0, "ord_empty");
        pq_empty_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        out_ready_i = 1'b0;
        do_start(8'd1);
        serve(8'h42, 8'h99, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid_o, rm_req_o, out_key_o, out_data_o, pop_cnt_o}
                !== {1'b1, 1'b0, 8'h42, 8'h99, 8'd0}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold: %0d bad cycles required 0 (valid=%b req=%b key=%h data=%h cnt=%0d)",
                     bad, out_valid_o, rm_req_o, out_key_o, out_data_o, pop_cnt_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid_o, pop_cnt_o} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL bp_release: valid=%b cnt=%0d required 0 1", out_valid_o, pop_cnt_o);
        end
        wait_done(8'd1, "bp");
    endtask

    task automatic test_timeout();
        int n = 0;
        int req_cycles = 0;
        do_start(8'd1);
        while (!rm_req_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (rm_req_o && req_cycles < 200) begin
            req_cycles++;
            @(negedge clk);
        end
        checks++;
        if (req_cycles !== 64) begin
            failures++;
            $display("FAIL tmo_len: rm_req cycles=%0d required 64", req_cycles);
        end
        checks++;
        if ({tmo_err_o, rm_req_o} !== 2'b10) begin
            failures++;
            $display("FAIL tmo_err: tmo_err=%b req=%b required 1 0", tmo_err_o, rm_req_o);
        end
        wait_done(8'd0, "tmo");
    endtask

    initial begin
        test_reset();
        test_ack_outside_req();
        test_fixed_pop();
        test_drain_all();
        test_order_err();
        test_backpressure();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
